// File: rtl/io_uart.sv
// IO-bus mapped 8N1 UART: DATA register at BASE_ADDR, STATUS at BASE_ADDR+1.
// Small TX and RX FIFOs buffer the CPU from the serial shifters.
module io_uart #(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] BASE_ADDR    = 8'h10,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_bus,
  output logic [7:0] o_bus,
  input  logic       i_ioSelect,
  input  logic [7:0] i_ioAddress,
  input  logic       i_ioNOE,
  input  logic       i_ioNWE,
  input  logic       i_rx,
  output logic       o_tx
);

  localparam int         PW          = $clog2(FIFO_DEPTH);
  localparam int         CW          = PW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [7:0] STATUS_ADDR = 8'(BASE_ADDR + 8'd1);
  localparam logic [7:0] BAUD_LAST   = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] BAUD_HALF   = 8'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;

  // Bus decode: a read strobe masks a simultaneous write.
  logic data_rd, data_wr, status_rd, status_wr;
  assign data_rd   = i_ioSelect && (i_ioAddress == BASE_ADDR)   && !i_ioNOE;
  assign data_wr   = i_ioSelect && (i_ioAddress == BASE_ADDR)   && !i_ioNWE && i_ioNOE;
  assign status_rd = i_ioSelect && (i_ioAddress == STATUS_ADDR) && !i_ioNOE;
  assign status_wr = i_ioSelect && (i_ioAddress == STATUS_ADDR) && !i_ioNWE && i_ioNOE;

  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          tx_full, tx_empty, rx_full, rx_empty;

  assign tx_full  = (tx_cnt_q == DEPTH_C);
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == DEPTH_C);
  assign rx_empty = (rx_cnt_q == '0);

  uart_state_e tx_state_q, tx_state_d;
  logic [7:0]  tx_baud_q, tx_baud_d, tx_shift_q, tx_shift_d;
  logic [2:0]  tx_bit_q, tx_bit_d;

  uart_state_e rx_state_q, rx_state_d;
  logic [7:0]  rx_baud_q, rx_baud_d, rx_shift_q, rx_shift_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic        rx_wait_q, rx_wait_d;
  logic        rx_sync1_q, rx_sync2_q;
  logic        rx_valid, frame_set;

  logic tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d, frame_q, frame_d;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_state_d = ST_START;
          tx_shift_d = tx_mem[tx_rptr_q];
          tx_pop     = 1'b1;
          tx_baud_d  = '0;
        end
      end
      ST_START: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_state_d = ST_DATA;
          tx_baud_d  = '0;
          tx_bit_d   = '0;
        end else begin
          tx_baud_d = tx_baud_q + 8'd1;
        end
      end
      ST_DATA: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d  = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
        end else begin
          tx_baud_d = tx_baud_q + 8'd1;
        end
      end
      ST_STOP: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = '0;
          // Back-to-back frames: the next start bit follows the stop bit directly.
          if (!tx_empty) begin
            tx_state_d = ST_START;
            tx_shift_d = tx_mem[tx_rptr_q];
            tx_pop     = 1'b1;
          end else begin
            tx_state_d = ST_IDLE;
          end
        end else begin
          tx_baud_d = tx_baud_q + 8'd1;
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_tx = 1'b1;
    if (tx_state_q == ST_START)     o_tx = 1'b0;
    else if (tx_state_q == ST_DATA) o_tx = tx_shift_q[0];
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_wait_d  = rx_wait_q;
    rx_valid   = 1'b0;
    frame_set  = 1'b0;
    unique case (rx_state_q)
      ST_IDLE: begin
        if (!rx_sync2_q) begin
          rx_state_d = ST_START;
          rx_baud_d  = '0;
        end
      end
      ST_START: begin
        if (rx_baud_q == BAUD_HALF) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync2_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_baud_d = rx_baud_q + 8'd1;
        end
      end
      ST_DATA: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
        end else begin
          rx_baud_d = rx_baud_q + 8'd1;
        end
      end
      ST_STOP: begin
        // After a framing error, hold here until the line returns high.
        if (rx_wait_q) begin
          if (rx_sync2_q) begin
            rx_wait_d  = 1'b0;
            rx_state_d = ST_IDLE;
          end
        end else if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d = '0;
          if (rx_sync2_q) begin
            rx_valid   = 1'b1;
            rx_state_d = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            rx_wait_d = 1'b1;
          end
        end else begin
          rx_baud_d = rx_baud_q + 8'd1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_push = data_wr && (!tx_full || tx_pop);
    rx_pop  = data_rd && !rx_empty;
    rx_push = rx_valid && (!rx_full || rx_pop);

    tx_wptr_d = tx_push ? tx_wptr_q + PW'(1) : tx_wptr_q;
    tx_rptr_d = tx_pop  ? tx_rptr_q + PW'(1) : tx_rptr_q;
    rx_wptr_d = rx_push ? rx_wptr_q + PW'(1) : rx_wptr_q;
    rx_rptr_d = rx_pop  ? rx_rptr_q + PW'(1) : rx_rptr_q;

    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + CW'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - CW'(1);
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + CW'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - CW'(1);

    // A clear and a set on the same edge leave the flag set.
    tx_ovf_d = (tx_ovf_q && !(status_wr && i_bus[6])) || (data_wr && tx_full && !tx_pop);
    rx_ovr_d = (rx_ovr_q && !(status_wr && i_bus[4])) || (rx_valid && rx_full && !rx_pop);
    frame_d  = (frame_q  && !(status_wr && i_bus[5])) || frame_set;
  end

  always_comb begin
    o_bus = 8'h00;
    if (!i_reset) begin
      if (data_rd && !rx_empty) o_bus = rx_mem[rx_rptr_q];
      else if (status_rd)
        o_bus = {(tx_state_q != ST_IDLE), tx_ovf_q, frame_q, rx_ovr_q,
                 rx_full, !rx_empty, tx_empty, tx_full};
    end
  end

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tx_state_q <= ST_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      rx_state_q <= ST_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_wait_q  <= 1'b0;
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      tx_ovf_q   <= 1'b0;
      rx_ovr_q   <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_wait_q  <= rx_wait_d;
      rx_sync1_q <= i_rx;
      rx_sync2_q <= rx_sync1_q;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_ovr_q   <= rx_ovr_d;
      frame_q    <= frame_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and counts alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= i_bus;
    if (rx_push) rx_mem[rx_wptr_q] <= rx_shift_d;
  end

endmodule

// File: tb/tb_io_uart.sv
// Directed bench for io_uart: serial TX/RX framing, FIFO limits, sticky flags, reset.
module tb_io_uart;

  localparam logic [7:0] DATA_A = 8'h10;
  localparam logic [7:0] STAT_A = 8'h11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bus_in = 8'h00;
  logic [7:0] bus_out;
  logic       io_sel = 1'b0;
  logic [7:0] io_addr = 8'h00;
  logic       io_noe = 1'b1;
  logic       io_nwe = 1'b1;
  logic       rx = 1'b1;
  logic       tx;

  int n_checks = 0;
  int n_fail   = 0;

  io_uart #(.CLKS_PER_BIT(16), .BASE_ADDR(8'h10), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_bus(bus_in), .o_bus(bus_out),
    .i_ioSelect(io_sel), .i_ioAddress(io_addr), .i_ioNOE(io_noe),
    .i_ioNWE(io_nwe), .i_rx(rx), .o_tx(tx)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Combinational STATUS read between clock edges: no edge is seen, so no action.
  task automatic status_peek(output logic [7:0] v);
    io_sel = 1'b1; io_addr = STAT_A; io_noe = 1'b0;
    #1 v = bus_out;
    io_noe = 1'b1; io_sel = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    io_sel = 1'b1; io_addr = a; bus_in = d; io_nwe = 1'b0;
    @(negedge clk);
    io_sel = 1'b0; io_nwe = 1'b1;
  endtask

  task automatic data_read(output logic [7:0] v);
    @(negedge clk);
    io_sel = 1'b1; io_addr = DATA_A; io_noe = 1'b0;
    #1 v = bus_out;
    @(negedge clk);
    io_sel = 1'b0; io_noe = 1'b1;
  endtask

  task automatic step_to(inout int k, input int target);
    while (k < target) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Bounded wait for the start bit; returns on the first negedge where o_tx is low.
  task automatic wait_tx_start(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx == 1'b0) break;
    end
    check(tag, tx, 1'b0);
  endtask

  // k counts negedges since the one just after the start bit began; ends at k=160.
  task automatic tx_frame(input string name, input logic [7:0] d, input int k0);
    int k;
    logic [7:0] st;
    logic exp_bit;
    k = k0;
    for (int b = 0; b < 10; b++) begin
      step_to(k, 8 + 16 * b);
      exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
      check($sformatf("%s_bit%0d", name, b), tx, exp_bit);
      if (b == 0) begin
        step_to(k, 15);
        check($sformatf("%s_start_end", name), tx, 1'b0);
      end
      if (b == 5) begin
        status_peek(st);
        check($sformatf("%s_busy", name), st[7], 1'b1);
      end
    end
    step_to(k, 160);
  endtask

  task automatic rx_send(input logic [7:0] d, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      rx = d[b];
      repeat (16) @(negedge clk);
    end
    rx = stop_bit;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  logic [7:0] st, rd;
  logic [7:0] burst [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] rx_bytes [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};

  initial begin
    // Reset state, including o_bus gating while reset is held.
    #12;
    check("rst_tx", tx, 1'b1);
    status_peek(st);
    check("rst_bus_zero", st, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    status_peek(st);
    check("rst_status", st, 8'h02);

    // Single frame 8'hA5.
    bus_write(DATA_A, 8'hA5);
    wait_tx_start("a5_start_seen");
    tx_frame("a5", 8'hA5, 0);
    check("a5_idle_after", tx, 1'b1);
    status_peek(st);
    check("a5_status_after", st, 8'h02);

    // Six writes on consecutive edges: one to the shifter, four queued, one dropped.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      io_sel = 1'b1; io_addr = DATA_A; bus_in = burst[i]; io_nwe = 1'b0;
    end
    @(negedge clk);
    io_sel = 1'b0; io_nwe = 1'b1;
    status_peek(st);
    check("burst_status_full", st, 8'hC1);
    tx_frame("b0", burst[0], 4);
    for (int i = 1; i < 5; i++) begin
      check($sformatf("b%0d_no_gap", i), tx, 1'b0);
      tx_frame($sformatf("b%0d", i), burst[i], 0);
    end
    repeat (40) @(negedge clk);
    check("burst_dropped_not_sent", tx, 1'b1);
    status_peek(st);
    check("burst_status_end", st, 8'h42);
    bus_write(STAT_A, 8'h40);
    status_peek(st);
    check("ovf_cleared", st, 8'h02);

    // Read and write strobes together on DATA: only the read acts.
    @(negedge clk);
    io_sel = 1'b1; io_addr = DATA_A; bus_in = 8'h77; io_noe = 1'b0; io_nwe = 1'b0;
    @(negedge clk);
    io_sel = 1'b0; io_noe = 1'b1; io_nwe = 1'b1;
    repeat (30) @(negedge clk);
    check("rdwr_no_tx", tx, 1'b1);
    status_peek(st);
    check("rdwr_status", st, 8'h02);

    // Receive one byte.
    rx_send(8'h3C, 1'b1);
    status_peek(st);
    check("rx3c_status", st, 8'h06);
    data_read(rd);
    check("rx3c_data", rd, 8'h3C);
    status_peek(st);
    check("rx3c_status_after", st, 8'h02);

    // Five bytes into a four-entry FIFO.
    for (int i = 0; i < 5; i++) rx_send(rx_bytes[i], 1'b1);
    status_peek(st);
    check("rx5_status", st, 8'h1E);
    for (int i = 0; i < 4; i++) begin
      data_read(rd);
      check($sformatf("rx5_data%0d", i), rd, rx_bytes[i]);
    end
    data_read(rd);
    check("rx5_empty_read", rd, 8'h00);
    status_peek(st);
    check("rx5_status_drained", st, 8'h12);
    bus_write(STAT_A, 8'h10);
    status_peek(st);
    check("ovr_cleared", st, 8'h02);

    // Framing error, then a short glitch.
    rx_send(8'hA5, 1'b0);
    status_peek(st);
    check("frame_status", st, 8'h22);
    bus_write(STAT_A, 8'h20);
    status_peek(st);
    check("frame_cleared", st, 8'h02);
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    status_peek(st);
    check("glitch_status", st, 8'h02);

    // Reset in the middle of a frame of zeros.
    bus_write(DATA_A, 8'h00);
    wait_tx_start("rst_frame_start_seen");
    repeat (40) @(negedge clk);
    check("rst_frame_data_low", tx, 1'b0);
    #2 rst = 1'b1;
    #1 check("rst_tx_async", tx, 1'b1);
    status_peek(st);
    check("rst_mid_bus_zero", st, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    status_peek(st);
    check("rst_mid_status", st, 8'h02);
    repeat (30) @(negedge clk);
    check("rst_mid_tx_idle", tx, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_uart.md
IO_UART -- requirements
Module: io_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clock cycles per serial bit, legal range 4..255.
REQ-002 Parameter BASE_ADDR, default 8'h10: IO address of the DATA register; STATUS register is at BASE_ADDR+1.
REQ-003 Parameter FIFO_DEPTH, default 4: entries per TX and RX FIFO, power of two.
REQ-004 i_clk  in  1  single system clock, all state changes on rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_bus  in  8  CPU data bus, write data.
REQ-007 o_bus  out  8  read data; 8'h00 whenever this block is not being read (wired-OR bus).
REQ-008 i_ioSelect  in  1  high when the current memory access targets IO space.
REQ-009 i_ioAddress  in  8  IO register address.
REQ-010 i_ioNOE  in  1  active-low read strobe.
REQ-011 i_ioNWE  in  1  active-low write strobe.
REQ-012 i_rx  in  1  serial input, idle high, asynchronous to i_clk.
REQ-013 o_tx  out  1  serial output, idle high.

Function
REQ-014 Block is the IO-bus responder: a register access is a rising edge where i_ioSelect=1 and i_ioAddress matches; reads also require i_ioNOE=0, writes also require i_ioNWE=0.
REQ-015 Each matching edge performs exactly one action; a strobe held N cycles performs N actions.
REQ-016 DATA read: o_bus combinationally shows RX FIFO head (8'h00 if empty); the edge pops one entry if not empty.
REQ-017 DATA write: edge pushes i_bus into TX FIFO if not full; write to full FIFO is dropped and sets sticky txOverflow.
REQ-018 STATUS read (combinational, no side effect): bit0 txFull, bit1 txEmpty, bit2 rxNotEmpty, bit3 rxFull, bit4 rxOverrun, bit5 framingError, bit6 txOverflow, bit7 txBusy (shifter active).
REQ-019 STATUS write clears every sticky bit (4,5,6) whose i_bus bit is 1; a clear and a new set in the same edge leaves the bit set.
REQ-020 Simultaneous read and write strobes on one edge: read action only.
REQ-021 FIFOs: binary pointers with wrap at FIFO_DEPTH, separate count; push and pop of the same FIFO on one edge keep count unchanged (push to full while popping is allowed only for TX shifter pop).
REQ-022 TX FSM states IDLE, START, DATA, STOP; IDLE->START on the edge after TX FIFO non-empty, popping head into shift register.
REQ-023 Frame 8N1, LSB first, each bit exactly CLKS_PER_BIT cycles; STOP->START directly if FIFO non-empty at end of stop bit (back-to-back frames, no idle gap), else IDLE.
REQ-024 RX: i_rx passed through 2-FF synchronizer; FSM states IDLE, START, DATA, STOP.
REQ-025 IDLE->START on synchronized falling edge; sample at CLKS_PER_BIT/2; if high then, return to IDLE (glitch rejected).
REQ-026 DATA bits sampled at mid-bit, LSB first; stop bit sampled at mid-bit.
REQ-027 Stop bit 0: byte discarded, framingError set, FSM waits for line high before IDLE.
REQ-028 Valid byte with RX FIFO full: byte discarded, rxOverrun set; FIFO content unchanged.
REQ-029 Valid byte pushed on the same edge as a CPU pop from a full RX FIFO: both succeed, no overrun.

Reset
REQ-030 i_reset high asynchronously forces: o_tx=1, both FSMs IDLE, FIFOs empty, pointers 0, all sticky flags 0, bit counters 0, synchronizer flops 1; o_bus=8'h00 while reset held.
REQ-031 Reset mid-frame aborts the frame; o_tx returns high immediately; no partial byte is retained.

Verification
REQ-032 Write 8'hA5 to DATA, CLKS_PER_BIT=16 -> o_tx low 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16 cycles; STATUS bit7 high during frame.
REQ-033 Write 5 bytes back-to-back, FIFO_DEPTH=4, TX idle -> first enters shifter, remaining 4 fill FIFO, none dropped; 6th write while full -> dropped, STATUS bit6=1; two frames abut with no idle gap.
REQ-034 Drive 8'h3C serially on i_rx -> STATUS bit2=1; DATA read returns 8'h3C, then STATUS bit2=0.
REQ-035 Receive 5 bytes without reading -> first 4 readable in order, STATUS bit4=1; STATUS write 8'h10 -> bit4=0.
REQ-036 Frame with stop bit 0 -> no FIFO push, STATUS bit5=1; 3-cycle low glitch on i_rx -> no frame, no flags.
REQ-037 Assert i_reset during TX DATA state -> o_tx=1 same cycle, STATUS reads 8'h02 after release.
